adc_cbuf_wr_ctrl: RTL and testbench

- Write side of the ADC circular buffer, directly upstream of the circular-buffer acquisition state machine.
- Continuously writes packed ADC words into the circular-buffer RAM.
- On each accepted trigger, waits for the post-trigger words to land, then queues the start address (trigger address minus pre-trigger length) in a first-word-fall-through (FWFT) FIFO.
- The acquisition state machine pops that FIFO with `trig_addr_rd_en` and reads the buffer from that address.

---
 rtl/adc_cbuf_pkg.sv | 16 +
 rtl/cbuf_trig_fifo.sv | 38 +++
 rtl/adc_cbuf_wr_ctrl.sv | 88 ++++++++
 tb/tb_adc_cbuf_wr_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_cbuf_pkg.sv
// adc_cbuf_pkg: shared constants for the ADC circular-buffer write controller.
package adc_cbuf_pkg;
   localparam int ADDR_W_DEF  = 12;
   localparam int FIFO_AW_DEF = 4;
   localparam int IGN_W       = 16;
   localparam int I_IDLE  = 0;
   localparam int I_PRIME = 1;
   localparam int I_ARMED = 2;
   localparam int I_POST  = 3;
   localparam int I_PUSH  = 4;
   localparam logic [4:0] ST_IDLE  = 5'b00001;
   localparam logic [4:0] ST_PRIME = 5'b00010;
   localparam logic [4:0] ST_ARMED = 5'b00100;
   localparam logic [4:0] ST_POST  = 5'b01000;
   localparam logic [4:0] ST_PUSH  = 5'b10000;
endpackage

// File: rtl/cbuf_trig_fifo.sv
// cbuf_trig_fifo: first-word-fall-through FIFO for trigger start addresses.
module cbuf_trig_fifo #(
   parameter int W  = 12,
   parameter int AW = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   logic [W-1:0] mem [2**AW];
   logic [AW:0]  wp, rp;
   logic         do_pop, do_push;
   assign empty   = wp == rp;
   assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign do_pop  = pop && !empty;
   // at full a push only fits when the head leaves in the same cycle
   assign do_push = push && (!full || do_pop);
   assign dout    = empty ? '0 : mem[rp[AW-1:0]];
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         wp <= '0;
         rp <= '0;
      end else if (clear) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (do_push) wp <= wp + 1'b1;
         if (do_pop) rp <= rp + 1'b1;
      end
   always_ff @(posedge clk)
      if (do_push && !clear) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/adc_cbuf_wr_ctrl.sv
// adc_cbuf_wr_ctrl: writes ADC words into the circular buffer and queues
// the start address of each captured trigger window.
module adc_cbuf_wr_ctrl
   import adc_cbuf_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int FIFO_AW = FIFO_AW_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              acq_enable,
   input  logic [31:0]       adc_dat,
   input  logic              adc_dat_valid,
   input  logic              trig_pulse,
   input  logic [ADDR_W-1:0] pre_trig_words,
   input  logic [ADDR_W-1:0] post_trig_words,
   input  logic              fifo_clear,
   output logic              buf_wr_en,
   output logic [ADDR_W-1:0] buf_wr_addr,
   output logic [31:0]       buf_wr_dat,
   input  logic              trig_addr_rd_en,
   output logic [ADDR_W-1:0] trig_addr,
   output logic              trig_addr_empty,
   output logic              trig_fifo_full,
   output logic              trig_overflow,
   output logic [IGN_W-1:0]  trig_ignored_cnt,
   output logic              armed
);
   logic [4:0]        st, st_nx;
   logic [ADDR_W-1:0] wr_ptr, prime_cnt, post_cnt, start;
   logic              wr, push, ign;
   assign wr    = adc_dat_valid && acq_enable;
   assign push  = st[I_PUSH];
   assign armed = st[I_ARMED];
   assign ign   = acq_enable && trig_pulse && (st[I_PRIME] || st[I_POST] || st[I_PUSH]);
   always_comb begin
      st_nx = st;
      if (!acq_enable) st_nx = ST_IDLE;
      else if (st[I_IDLE]) st_nx = ST_PRIME;
      else if (st[I_PRIME] && (prime_cnt == '0 || (wr && prime_cnt == ADDR_W'(1)))) st_nx = ST_ARMED;
      else if (st[I_ARMED] && trig_pulse) st_nx = post_trig_words == '0 ? ST_PUSH : ST_POST;
      else if (st[I_POST] && (post_cnt == '0 || (wr && post_cnt == ADDR_W'(1)))) st_nx = ST_PUSH;
      else if (st[I_PUSH]) st_nx = ST_ARMED;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         st               <= ST_IDLE;
         wr_ptr           <= '0;
         prime_cnt        <= '0;
         post_cnt         <= '0;
         start            <= '0;
         buf_wr_en        <= 1'b0;
         buf_wr_addr      <= '0;
         buf_wr_dat       <= '0;
         trig_overflow    <= 1'b0;
         trig_ignored_cnt <= '0;
      end else begin
         st          <= st_nx;
         buf_wr_en   <= wr;
         buf_wr_addr <= wr_ptr;
         buf_wr_dat  <= adc_dat;
         if (wr) wr_ptr <= wr_ptr + 1'b1;
         if (st[I_IDLE]) prime_cnt <= pre_trig_words;
         else if (st[I_PRIME] && wr && prime_cnt != '0) prime_cnt <= prime_cnt - 1'b1;
         if (st[I_ARMED] && acq_enable && trig_pulse) begin
            start    <= wr_ptr - pre_trig_words;
            post_cnt <= post_trig_words;
         end else if (st[I_POST] && wr && post_cnt != '0) post_cnt <= post_cnt - 1'b1;
         if (fifo_clear) begin
            trig_overflow    <= 1'b0;
            trig_ignored_cnt <= '0;
         end else begin
            if (push && trig_fifo_full && !trig_addr_rd_en) trig_overflow <= 1'b1;
            if (ign && trig_ignored_cnt != '1) trig_ignored_cnt <= trig_ignored_cnt + 1'b1;
         end
      end
   cbuf_trig_fifo #(.W(ADDR_W), .AW(FIFO_AW)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .clear (fifo_clear),
      .push  (push),
      .pop   (trig_addr_rd_en),
      .din   (start),
      .dout  (trig_addr),
      .full  (trig_fifo_full),
      .empty (trig_addr_empty)
   );
endmodule

// File: tb/tb_adc_cbuf_wr_ctrl.sv
// tb_adc_cbuf_wr_ctrl: scoreboard bench for the circular-buffer write controller.
module tb_adc_cbuf_wr_ctrl;
   localparam int AW = 12;
   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          acq_enable = 1'b0;
   logic [31:0]   adc_dat = '0;
   logic          adc_dat_valid = 1'b0;
   logic          trig_pulse = 1'b0;
   logic [AW-1:0] pre_trig_words = '0;
   logic [AW-1:0] post_trig_words = '0;
   logic          fifo_clear = 1'b0;
   logic          buf_wr_en;
   logic [AW-1:0] buf_wr_addr;
   logic [31:0]   buf_wr_dat;
   logic          trig_addr_rd_en = 1'b0;
   logic [AW-1:0] trig_addr;
   logic          trig_addr_empty;
   logic          trig_fifo_full;
   logic          trig_overflow;
   logic [15:0]   trig_ignored_cnt;
   logic          armed;
   int            tests = 0;
   int            fails = 0;
   logic [AW-1:0] q[$];
   logic [AW-1:0] mptr, exp_addr;
   logic [31:0]   exp_dat;
   logic          exp_en;
   int            n;

   adc_cbuf_wr_ctrl dut (
      .clk              (clk),
      .reset            (reset),
      .acq_enable       (acq_enable),
      .adc_dat          (adc_dat),
      .adc_dat_valid    (adc_dat_valid),
      .trig_pulse       (trig_pulse),
      .pre_trig_words   (pre_trig_words),
      .post_trig_words  (post_trig_words),
      .fifo_clear       (fifo_clear),
      .buf_wr_en        (buf_wr_en),
      .buf_wr_addr      (buf_wr_addr),
      .buf_wr_dat       (buf_wr_dat),
      .trig_addr_rd_en  (trig_addr_rd_en),
      .trig_addr        (trig_addr),
      .trig_addr_empty  (trig_addr_empty),
      .trig_fifo_full   (trig_fifo_full),
      .trig_overflow    (trig_overflow),
      .trig_ignored_cnt (trig_ignored_cnt),
      .armed            (armed)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // reference write pointer and one-cycle-delayed write-port expectations
   always @(posedge clk or posedge reset)
      if (reset) begin
         mptr     <= '0;
         exp_en   <= 1'b0;
         exp_addr <= '0;
         exp_dat  <= '0;
      end else begin
         exp_en   <= acq_enable && adc_dat_valid;
         exp_addr <= mptr;
         exp_dat  <= adc_dat;
         if (acq_enable && adc_dat_valid) mptr <= mptr + 1'b1;
      end

   always @(negedge clk)
      if (!reset) begin
         chk("wr_en", {31'd0, buf_wr_en}, {31'd0, exp_en});
         chk("wr_addr", {20'd0, buf_wr_addr}, {20'd0, exp_addr});
         chk("wr_dat", buf_wr_dat, exp_dat);
      end

   task automatic tick();
      @(posedge clk);
      #1;
      adc_dat = $urandom;
   endtask

   task automatic fire(input bit keep);
      if (keep) q.push_back(mptr - pre_trig_words);
      trig_pulse = 1'b1;
      tick();
      trig_pulse = 1'b0;
   endtask

   task automatic drain();
      if (q.size() == 0) chk("q_under", 1, 0);
      else chk("head", {20'd0, trig_addr}, {20'd0, q.pop_front()});
      trig_addr_rd_en = 1'b1;
      tick();
      trig_addr_rd_en = 1'b0;
   endtask

   task automatic wait_armed();
      for (int i = 0; i < 100 && !armed; i++) tick();
      chk("armed_wait", {31'd0, armed}, 1);
   endtask

   task automatic wait_nonempty();
      for (int i = 0; i < 100 && trig_addr_empty; i++) tick();
      chk("push_wait", {31'd0, trig_addr_empty}, 0);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_en"}, {31'd0, buf_wr_en}, 0);
      chk({tag, "_addr"}, {20'd0, buf_wr_addr}, 0);
      chk({tag, "_dat"}, buf_wr_dat, 0);
      chk({tag, "_empty"}, {31'd0, trig_addr_empty}, 1);
      chk({tag, "_taddr"}, {20'd0, trig_addr}, 0);
      chk({tag, "_full"}, {31'd0, trig_fifo_full}, 0);
      chk({tag, "_ovf"}, {31'd0, trig_overflow}, 0);
      chk({tag, "_ign"}, {16'd0, trig_ignored_cnt}, 0);
      chk({tag, "_armed"}, {31'd0, armed}, 0);
   endtask

   initial begin
      #2 reset = 1'b1;
      #2 chk_reset("rst");
      repeat (3) tick();
      reset = 1'b0;
      tick();
      // enable with continuous data: IDLE write then 8 priming writes
      pre_trig_words  = 12'd8;
      post_trig_words = 12'd16;
      acq_enable      = 1'b1;
      adc_dat_valid   = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         tick();
         chk("seq_addr", {20'd0, buf_wr_addr}, k - 1);
         chk("prime_armed", {31'd0, armed}, {31'd0, k >= 9});
         chk("prime_empty", {31'd0, trig_addr_empty}, 1);
      end
      for (int i = 0; i < 200 && mptr != 12'd100; i++) tick();
      chk("ptr100", {20'd0, mptr}, 100);
      fire(1);
      n = 1;
      while (trig_addr_empty && n < 100) begin
         tick();
         n++;
      end
      chk("lat18", n, 18);
      chk("basic", {20'd0, trig_addr}, 92);
      drain();
      chk("basic_empty", {31'd0, trig_addr_empty}, 1);
      // wrap-around of the start address
      for (int i = 0; i < 5000 && !(mptr == 12'd3 && armed); i++) tick();
      chk("ptr3", {20'd0, mptr}, 3);
      fire(1);
      wait_nonempty();
      chk("wrap", {20'd0, trig_addr}, 4091);
      drain();
      // overflow with post=0
      acq_enable = 1'b0;
      tick();
      post_trig_words = 12'd0;
      acq_enable = 1'b1;
      wait_armed();
      for (int i = 0; i < 17; i++) begin
         fire(i < 16);
         tick();
         tick();
         if (i == 15) begin
            chk("full16", {31'd0, trig_fifo_full}, 1);
            chk("ovf16", {31'd0, trig_overflow}, 0);
         end
      end
      chk("ovf17", {31'd0, trig_overflow}, 1);
      chk("full17", {31'd0, trig_fifo_full}, 1);
      chk("ign0", {16'd0, trig_ignored_cnt}, 0);
      fire(1);
      drain();
      chk("full_pp", {31'd0, trig_fifo_full}, 1);
      for (int i = 0; i < 16; i++) drain();
      chk("ovf_empty", {31'd0, trig_addr_empty}, 1);
      chk("ovf_qsz", q.size(), 0);
      // ignored trigger during POST, then abort
      acq_enable = 1'b0;
      tick();
      post_trig_words = 12'd16;
      acq_enable = 1'b1;
      wait_armed();
      fire(1);
      wait_nonempty();
      fire(0);
      repeat (3) tick();
      trig_pulse = 1'b1;
      tick();
      trig_pulse = 1'b0;
      chk("ign_post", {16'd0, trig_ignored_cnt}, 1);
      repeat (2) tick();
      acq_enable = 1'b0;
      tick();
      chk("abort_armed", {31'd0, armed}, 0);
      repeat (30) tick();
      chk("abort_full", {31'd0, trig_fifo_full}, 0);
      chk("abort_empty", {31'd0, trig_addr_empty}, 0);
      drain();
      chk("abort_nopush", {31'd0, trig_addr_empty}, 1);
      chk("ovf_kept", {31'd0, trig_overflow}, 1);
      chk("ign_kept", {16'd0, trig_ignored_cnt}, 1);
      // fifo_clear in the PUSH cycle
      acq_enable = 1'b1;
      wait_armed();
      fire(0);
      repeat (16) tick();
      fifo_clear = 1'b1;
      tick();
      fifo_clear = 1'b0;
      chk("clr_empty", {31'd0, trig_addr_empty}, 1);
      chk("clr_ovf", {31'd0, trig_overflow}, 0);
      chk("clr_ign", {16'd0, trig_ignored_cnt}, 0);
      repeat (3) tick();
      chk("clr_still_empty", {31'd0, trig_addr_empty}, 1);
      // trigger in the PUSH cycle is ignored
      fire(1);
      repeat (16) tick();
      trig_pulse = 1'b1;
      tick();
      trig_pulse = 1'b0;
      chk("ign_push", {16'd0, trig_ignored_cnt}, 1);
      chk("rearm", {31'd0, armed}, 1);
      chk("push_done", {31'd0, trig_addr_empty}, 0);
      chk("push_head", {20'd0, trig_addr}, {20'd0, q[0]});
      // asynchronous reset mid-POST
      fire(0);
      repeat (5) tick();
      #2 reset = 1'b1;
      #1 chk_reset("arst");
      q.delete();
      repeat (2) tick();
      reset = 1'b0;
      tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
